// File: rtl/mem_pkg.sv
// Shared sizes and word/address types for the 256 x 16 CPU memory.
package mem_pkg;

    localparam int MEM_ADDR_W = 8;
    localparam int MEM_DATA_W = 16;
    localparam int MEM_DEPTH  = 256;

    typedef logic [MEM_DATA_W-1:0] mem_word_t;
    typedef logic [MEM_ADDR_W-1:0] mem_addr_t;

endpackage : mem_pkg

// File: rtl/a_256_16_memory.sv
// Single-port 256 x 16 synchronous memory: enable=1 writes (write-through to data_out),
// enable=0 reads with one cycle of latency; synchronous reset clears every word.
module a_256_16_memory
    import mem_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DATA_W = MEM_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out
);

    mem_word_t mem_q [MEM_DEPTH];
    mem_word_t data_out_q;

    // NOTE: the whole array is reset, so it maps to flops/distributed RAM rather than block RAM.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            data_out_q <= '0;
        end else if (enable) begin
            // An unknown write address must not corrupt any word; $isunknown is constant 0 in synthesis.
            if ($isunknown(address)) begin
                data_out_q <= 'x;
            end else begin
                mem_q[address] <= data_in;
                data_out_q     <= data_in;
            end
        end else begin
            data_out_q <= mem_q[address];
        end
    end

    assign data_out = data_out_q;

endmodule : a_256_16_memory

// File: tb/tb_a_256_16_memory.sv
// Self-checking bench for a_256_16_memory: per-cycle comparison against an array model,
// directed pins for the listed scenarios, then randomized traffic with occasional resets.
module tb_a_256_16_memory;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [7:0]  address;
    logic [15:0] data_in;
    logic [15:0] data_out;

    int n_checks = 0;
    int n_fail   = 0;

    a_256_16_memory dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .address  (address),
        .data_in  (data_in),
        .data_out (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: data_out=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain array plus the word that must appear on data_out after each edge.
    logic [15:0] ref_mem [256];
    logic [15:0] exp_out;
    bit          model_known = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            foreach (ref_mem[i]) ref_mem[i] = 16'h0000;
            exp_out     = 16'h0000;
            model_known = 1'b1;
        end else if (enable) begin
            if ($isunknown(address)) begin
                exp_out = 16'hxxxx;
            end else begin
                ref_mem[address] = data_in;
                exp_out          = data_in;
            end
        end else begin
            exp_out = ref_mem[address];
        end
        #1;
        if (model_known) check("model", data_out, exp_out);
    end

    // Apply one cycle of inputs at the falling edge and return just after the rising edge.
    task automatic op(input logic rst, input logic en, input logic [7:0] addr, input logic [15:0] din);
        @(negedge clk);
        reset   = rst;
        enable  = en;
        address = addr;
        data_in = din;
        @(posedge clk);
        #1;
    endtask

    task automatic wr_pin(input logic [7:0] addr, input logic [15:0] din, input string name);
        op(1'b0, 1'b1, addr, din);
        check(name, data_out, din);
    endtask

    task automatic rd_pin(input logic [7:0] addr, input logic [15:0] exp, input string name);
        op(1'b0, 1'b0, addr, 16'h0000);
        check(name, data_out, exp);
    endtask

    logic [7:0] wr_addr [5] = '{8'h01, 8'h02, 8'hAA, 8'hBB, 8'hCC};
    logic [15:0] wr_data [5] = '{16'h0001, 16'h0002, 16'hAAAA, 16'hBBBB, 16'hCCCC};

    initial begin
        reset   = 1'b0;
        enable  = 1'b0;
        address = 8'h00;
        data_in = 16'h0000;

        // Reset, then the cleared state.
        op(1'b1, 1'b0, 8'h00, 16'h0000);
        check("reset_out", data_out, 16'h0000);
        rd_pin(8'h00, 16'h0000, "rst_rd_00");
        rd_pin(8'h7F, 16'h0000, "rst_rd_7f");
        rd_pin(8'hFF, 16'h0000, "rst_rd_ff");

        // Write-through echo, then read-back.
        for (int i = 0; i < 5; i++) wr_pin(wr_addr[i], wr_data[i], "wr_echo");
        for (int i = 0; i < 5; i++) rd_pin(wr_addr[i], wr_data[i], "rd_back");

        // Unknown address during a write; the model decides which words must survive.
        op(1'b0, 1'b1, 8'hxx, 16'hxxxx);
        op(1'b0, 1'b0, 8'h01, 16'h0000);
        op(1'b0, 1'b0, 8'hAA, 16'h0000);
        op(1'b0, 1'b0, 8'hCC, 16'h0000);

        // Overwrite, then read on the very next cycle.
        wr_pin(8'h10, 16'h0055, "ovw_1");
        wr_pin(8'h10, 16'hA5A5, "ovw_2");
        rd_pin(8'h10, 16'hA5A5, "ovw_rd");

        // Address boundaries and their neighbours.
        wr_pin(8'h00, 16'h1234, "bnd_wr_00");
        wr_pin(8'hFF, 16'hFFFF, "bnd_wr_ff");
        rd_pin(8'h00, 16'h1234, "bnd_rd_00");
        rd_pin(8'hFF, 16'hFFFF, "bnd_rd_ff");
        rd_pin(8'hFE, 16'h0000, "bnd_rd_fe");
        op(1'b0, 1'b0, 8'h01, 16'h0000);

        // Reset wins over a simultaneous write.
        wr_pin(8'h42, 16'hBEEF, "pre_rst_wr");
        op(1'b1, 1'b1, 8'h43, 16'h1111);
        check("mid_rst_out", data_out, 16'h0000);
        rd_pin(8'h42, 16'h0000, "mid_rst_42");
        rd_pin(8'h43, 16'h0000, "mid_rst_43");

        // Randomized traffic; a small address pool forces frequent read-after-write hits.
        for (int n = 0; n < 2000; n++) begin
            logic [7:0] a;
            logic [15:0] d;
            logic rst;
            logic en;
            a   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
            d   = 16'($urandom);
            rst = ($urandom_range(0, 99) == 0);
            en  = 1'($urandom);
            op(rst, en, a, d);
        end

        op(1'b0, 1'b0, 8'h00, 16'h0000);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_a_256_16_memory
